alu_issue_stage: RTL and testbench

Operand-issue and writeback stage that sits directly upstream of the registered ALU (`alu_with_flop`) in the mini-core datapath. It accepts decoded instructions over a valid/ready handshake and reads operands from an internal register file. It drives the ALU's `a`/`b`/`sel` inputs from an issue register, then writes the ALU's registered result and flag back into the register file. It owns hazard detection: it forwards from the writeback stage and stalls on a dependency on the instruction currently in the ALU.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_regfile.sv | 41 ++++
 rtl/alu_issue_stage.sv | 150 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the registered ALU, the issue stage and
// their benches.
//   ALU_SEL_W        width of the ALU operation select
//   ALU_ADD..ALU_SRA named operation encodings carried on sel
//   ALU_NREG_DEFAULT default architectural register count
//   alu_idx_w()      index width for a given register count
package alu_pkg;

  localparam int ALU_SEL_W = 4;

  localparam logic [ALU_SEL_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_SEL_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_SEL_W-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_SEL_W-1:0] ALU_XOR = 4'd4;
  localparam logic [ALU_SEL_W-1:0] ALU_SLT = 4'd5;
  localparam logic [ALU_SEL_W-1:0] ALU_SLL = 4'd6;
  localparam logic [ALU_SEL_W-1:0] ALU_SRL = 4'd7;
  localparam logic [ALU_SEL_W-1:0] ALU_SRA = 4'd8;

  localparam int ALU_NREG_DEFAULT = 8;

  // Register index width; a single-register file still gets one bit.
  function automatic int alu_idx_w(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREG x WIDTH architectural register file.
//   clk, rst       clock, synchronous active-high reset (clears every entry)
//   raddr1/rdata1  combinational read port 1
//   raddr2/rdata2  combinational read port 2
//   we/waddr/wdata synchronous write port
// Register 0 reads as zero and ignores writes.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREG  = ALU_NREG_DEFAULT,
  parameter int AW    = alu_idx_w(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata1,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata2,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata
);

  logic [WIDTH-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  // r0 is forced here as well, so no write path can ever make it nonzero.
  assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand issue and writeback around a registered ALU.
//   clk, rst            clock, synchronous active-high reset
//   instr_valid/ready   instruction handshake
//   instr_sel           ALU operation, forwarded unmodified
//   instr_rd/rs1/rs2    destination and source register indices
//   instr_imm_en/imm    operand b comes from imm instead of rs2
//   alu_a/alu_b/alu_sel registered ALU operands
//   alu_out/alu_flag    registered ALU result and flag
//   wb_valid/rd/data    writeback of the ALU result
//   status_flag         flag of the most recent writeback (sticky)
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both high. instr_ready is combinational from the source
// fields and pipeline state, so the offered fields may change while
// instr_ready is low, but must stay put once it is high until the edge.
//
// Pipeline: ISSUE loads alu_a/b/sel (edge N), the ALU registers its result
// (edge N+1), WB writes the register file and status_flag (edge N+2).
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREG  = ALU_NREG_DEFAULT,
  parameter int AW    = alu_idx_w(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [ALU_SEL_W-1:0] instr_sel,
  input  logic [AW-1:0]        instr_rd,
  input  logic [AW-1:0]        instr_rs1,
  input  logic [AW-1:0]        instr_rs2,
  input  logic                 instr_imm_en,
  input  logic [WIDTH-1:0]     instr_imm,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [ALU_SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic                 alu_flag,
  output logic                 wb_valid,
  output logic [AW-1:0]        wb_rd,
  output logic [WIDTH-1:0]     wb_data,
  output logic                 status_flag
);

  logic             ex_valid;
  logic [AW-1:0]    ex_rd;
  logic [WIDTH-1:0] rf_rdata1;
  logic [WIDTH-1:0] rf_rdata2;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             stall;
  logic             accept;

  alu_regfile #(
    .WIDTH (WIDTH),
    .NREG  (NREG),
    .AW    (AW)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (instr_rs1),
    .rdata1 (rf_rdata1),
    .raddr2 (instr_rs2),
    .rdata2 (rf_rdata2),
    .we     (wb_valid),
    .waddr  (wb_rd),
    .wdata  (alu_out)
  );

  // The instruction in EX has no result yet, so a consumer must wait one
  // cycle; once that producer reaches WB its value is forwarded. r0 is never
  // a real dependency.
  always_comb begin
    stall = 1'b0;
    if (ex_valid && (ex_rd != '0)) begin
      if (instr_rs1 == ex_rd) begin
        stall = 1'b1;
      end
      if (!instr_imm_en && (instr_rs2 == ex_rd)) begin
        stall = 1'b1;
      end
    end
  end

  assign instr_ready = !rst && !stall;
  assign accept      = instr_valid && instr_ready;

  // Operand selection: r0 beats forwarding, forwarding beats the register
  // file. Forwarding also covers the register being written this same cycle.
  always_comb begin
    op_a = rf_rdata1;
    if (instr_rs1 == '0) begin
      op_a = '0;
    end else if (wb_valid && (wb_rd == instr_rs1)) begin
      op_a = alu_out;
    end
  end

  always_comb begin
    op_b = rf_rdata2;
    if (instr_imm_en) begin
      op_b = instr_imm;
    end else if (instr_rs2 == '0) begin
      op_b = '0;
    end else if (wb_valid && (wb_rd == instr_rs2)) begin
      op_b = alu_out;
    end
  end

  // Issue register. On a bubble the operands hold; the ALU recomputes the
  // old operation but nothing tracks that result.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= '0;
      ex_valid <= 1'b0;
      ex_rd    <= '0;
    end else begin
      ex_valid <= accept;
      if (accept) begin
        alu_a   <= op_a;
        alu_b   <= op_b;
        alu_sel <= instr_sel;
        ex_rd   <= instr_rd;
      end
    end
  end

  // EX -> WB tracking and the sticky flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      status_flag <= 1'b0;
    end else begin
      wb_valid <= ex_valid;
      wb_rd    <= ex_rd;
      if (wb_valid) begin
        status_flag <= alu_flag;
      end
    end
  end

  // Gated so the writeback bus reads zero whenever nothing is being written.
  assign wb_data = wb_valid ? alu_out : '0;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed bench for alu_issue_stage with a behavioural
// registered ALU in the loop and a scoreboard on the writeback port.
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int W     = 32;
  localparam int NREG  = 8;
  localparam int AW    = 3;
  localparam int EXP_W = 1 + AW + W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic                 instr_valid;
  logic                 instr_ready;
  logic [ALU_SEL_W-1:0] instr_sel;
  logic [AW-1:0]        instr_rd;
  logic [AW-1:0]        instr_rs1;
  logic [AW-1:0]        instr_rs2;
  logic                 instr_imm_en;
  logic [W-1:0]         instr_imm;
  logic [W-1:0]         alu_a;
  logic [W-1:0]         alu_b;
  logic [ALU_SEL_W-1:0] alu_sel;
  logic [W-1:0]         alu_out;
  logic                 alu_flag;
  logic                 wb_valid;
  logic [AW-1:0]        wb_rd;
  logic [W-1:0]         wb_data;
  logic                 status_flag;

  alu_issue_stage #(
    .WIDTH (W),
    .NREG  (NREG)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_sel    (instr_sel),
    .instr_rd     (instr_rd),
    .instr_rs1    (instr_rs1),
    .instr_rs2    (instr_rs2),
    .instr_imm_en (instr_imm_en),
    .instr_imm    (instr_imm),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_sel      (alu_sel),
    .alu_out      (alu_out),
    .alu_flag     (alu_flag),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .status_flag  (status_flag)
  );

  // ---------------- registered ALU stand-in ----------------
  // flag: SLT result bit for ALU_SLT, zero-result for everything else.
  logic [W-1:0] alu_res_c;
  logic         alu_flag_c;
  always_comb begin
    alu_res_c = '0;
    case (alu_sel)
      ALU_ADD: alu_res_c = alu_a + alu_b;
      ALU_SUB: alu_res_c = alu_a - alu_b;
      ALU_AND: alu_res_c = alu_a & alu_b;
      ALU_OR:  alu_res_c = alu_a | alu_b;
      ALU_XOR: alu_res_c = alu_a ^ alu_b;
      ALU_SLT: alu_res_c = ($signed(alu_a) < $signed(alu_b)) ? 1 : 0;
      default: alu_res_c = '0;
    endcase
    alu_flag_c = (alu_sel == ALU_SLT) ? alu_res_c[0] : (alu_res_c == '0);
  end

  always_ff @(posedge clk) begin
    alu_out  <= alu_res_c;
    alu_flag <= alu_flag_c;
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one entry per writeback, and checks status_flag on the
  // following negedge (it loads at the end of the WB cycle).
  logic pend_flag_valid = 1'b0;
  logic pend_flag       = 1'b0;
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (pend_flag_valid) begin
      check("status_flag", {31'd0, status_flag}, {31'd0, pend_flag});
      pend_flag_valid = 1'b0;
    end
    if (wb_valid) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wb_rd", {29'd0, wb_rd}, {29'd0, e[W+AW-1:W]});
        check("wb_data", wb_data, e[W-1:0]);
        pend_flag       = e[EXP_W-1];
        pend_flag_valid = 1'b1;
      end
    end
  end

  // ---------------- driver ----------------
  // Offers one instruction, waits (bounded) for ready, and returns one step
  // after the accepting edge with instr_valid still high.
  task automatic issue(input logic [ALU_SEL_W-1:0] sel, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic imm_en, input logic [W-1:0] imm,
                       input logic expect_wb, input logic [W-1:0] exp_data,
                       input logic exp_flag, output int stalls);
    instr_sel    = sel;
    instr_rd     = rd;
    instr_rs1    = rs1;
    instr_rs2    = rs2;
    instr_imm_en = imm_en;
    instr_imm    = imm;
    instr_valid  = 1'b1;
    stalls       = 0;
    #1;
    while (!instr_ready && stalls < 20) begin
      @(posedge clk);
      #1;
      stalls++;
    end
    if (!instr_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      instr_valid = 1'b0;
    end else begin
      if (expect_wb) exp_q.push_back({exp_flag, rd, exp_data});
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int st;
    rst = 1'b1;
    instr_valid = 1'b0;
    instr_sel = '0; instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0;
    instr_imm_en = 1'b0; instr_imm = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, instr_ready}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_status", {31'd0, status_flag}, 32'd0);
    rst = 1'b0;

    // Immediate issue, independent: no stalls.
    issue(ALU_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'd5, 1'b1, 32'd5, 1'b0, st);
    check("imm1_stalls", st, 32'd0);
    issue(ALU_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 32'd7, 1'b1, 32'd7, 1'b0, st);
    check("imm2_stalls", st, 32'd0);

    // r3 = r1 + r2 right after r2 is issued: r2 still in EX -> one stall.
    issue(ALU_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0, 1'b1, 32'd12, 1'b0, st);
    check("dep0_stalls", st, 32'd1);
    // r4 = r3 + r1: one stall, then r3 forwarded from WB.
    issue(ALU_ADD, 3'd4, 3'd3, 3'd1, 1'b0, 32'd0, 1'b1, 32'd17, 1'b0, st);
    check("dep_stalls", st, 32'd1);
    check("dep_fwd_a", alu_a, 32'd12);

    // Dependency two back: forwarded, no stall.
    issue(ALU_ADD, 3'd5, 3'd0, 3'd0, 1'b1, 32'd3, 1'b1, 32'd3, 1'b0, st);
    issue(ALU_ADD, 3'd6, 3'd0, 3'd0, 1'b1, 32'd4, 1'b1, 32'd4, 1'b0, st);
    issue(ALU_ADD, 3'd7, 3'd5, 3'd0, 1'b1, 32'd10, 1'b1, 32'd13, 1'b0, st);
    check("two_back_stalls", st, 32'd0);
    check("two_back_a", alu_a, 32'd3);
    // Three or more back: both operands from the register file.
    issue(ALU_ADD, 3'd2, 3'd4, 3'd3, 1'b0, 32'd0, 1'b1, 32'd29, 1'b0, st);
    check("rf_stalls", st, 32'd0);
    check("rf_a", alu_a, 32'd17);
    check("rf_b", alu_b, 32'd12);

    // Register 0: writes pulse WB but data is dropped; reads give 0 even
    // while r0 is the WB destination.
    issue(ALU_ADD, 3'd6, 3'd0, 3'd0, 1'b1, 32'd0, 1'b1, 32'd0, 1'b1, st);
    issue(ALU_ADD, 3'd0, 3'd0, 3'd0, 1'b1, 32'd9, 1'b1, 32'd9, 1'b0, st);
    issue(ALU_ADD, 3'd6, 3'd0, 3'd0, 1'b1, 32'd2, 1'b1, 32'd2, 1'b0, st);
    check("r0_ex_stalls", st, 32'd0);
    check("r0_ex_a", alu_a, 32'd0);
    issue(ALU_ADD, 3'd5, 3'd0, 3'd0, 1'b1, 32'd1, 1'b1, 32'd1, 1'b0, st);
    check("r0_wb_a", alu_a, 32'd0);

    // Flag: 5 < -1 is false, 5 < 6 is true; flag must then hold while idle.
    issue(ALU_SLT, 3'd5, 3'd1, 3'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b0, st);
    issue(ALU_SLT, 3'd4, 3'd1, 3'd0, 1'b1, 32'd6, 1'b1, 32'd1, 1'b1, st);
    idle(6);
    check("flag_hold", {31'd0, status_flag}, 32'd1);
    issue(ALU_SUB, 3'd3, 3'd1, 3'd0, 1'b1, 32'd5, 1'b1, 32'd0, 1'b1, st);
    issue(ALU_OR, 3'd6, 3'd1, 3'd4, 1'b0, 32'd0, 1'b1, 32'd5, 1'b0, st);
    issue(ALU_SUB, 3'd3, 3'd1, 3'd0, 1'b1, 32'd5, 1'b1, 32'd0, 1'b1, st);
    idle(4);

    // Reset mid-stream: the instruction in EX must never write back.
    issue(ALU_ADD, 3'd6, 3'd1, 3'd0, 1'b1, 32'd1, 1'b0, 32'd0, 1'b0, st);
    rst = 1'b1;
    instr_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", {31'd0, instr_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_ready2", {31'd0, instr_ready}, 32'd0);
    check("mid_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("mid_rst_alu_a", alu_a, 32'd0);
    check("mid_rst_alu_b", alu_b, 32'd0);
    check("mid_rst_alu_sel", {28'd0, alu_sel}, 32'd0);
    check("mid_rst_status", {31'd0, status_flag}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("post_rst_wb_rd", {29'd0, wb_rd}, 32'd0);

    // Register file was cleared.
    issue(ALU_ADD, 3'd7, 3'd1, 3'd2, 1'b0, 32'd0, 1'b1, 32'd0, 1'b1, st);
    check("post_rst_a", alu_a, 32'd0);
    check("post_rst_b", alu_b, 32'd0);
    issue(ALU_OR, 3'd5, 3'd4, 3'd6, 1'b0, 32'd0, 1'b1, 32'd0, 1'b1, st);
    idle(5);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
